// File: rtl/img_decimator_pkg.sv
// Shared constants and helpers for the pixel decimator and its ping-pong frame banks.
package img_decimator_pkg;

  localparam int ADR_LEN = 9;
  localparam int UINT_8  = 8;
  localparam int IMG_DIM = 16;
  localparam int IMG_LEN = IMG_DIM * IMG_DIM;
  localparam int IMG_AW  = $clog2(IMG_LEN);

  typedef logic [UINT_8-1:0] uint8_t;

  // Address 0 is the bias input; addresses past the image read as zero.
  function automatic uint8_t read_mux(input logic [ADR_LEN-1:0] addr,
                                      input uint8_t             bias,
                                      input uint8_t             bank_data);
    uint8_t res;
    if (addr == ADR_LEN'(0)) begin
      res = bias;
    end else if (addr <= ADR_LEN'(IMG_LEN)) begin
      res = bank_data;
    end else begin
      res = 8'h00;
    end
    return res;
  endfunction

endpackage

// File: rtl/img_decimator_frame_bank.sv
// One 256x8 image bank: synchronous write, combinational read, cleared by reset.
module frame_bank
  import img_decimator_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IMG_AW-1:0] waddr,
  input  logic [UINT_8-1:0] wd,
  input  logic [IMG_AW-1:0] raddr,
  output logic [UINT_8-1:0] rd
);

  logic [UINT_8-1:0] mem_q [IMG_LEN];

  // Storage array with write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < IMG_LEN; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (we) begin
      mem_q[waddr] <= wd;
    end
  end

  assign rd = mem_q[raddr];

endmodule

// File: rtl/img_decimator.sv
// Box-averages a raw 8-bit pixel stream down to OUT_DIM x OUT_DIM and hands completed
// frames to the network through a ping-pong pair of frame banks.
module img_decimator
  import img_decimator_pkg::*;
#(
  parameter int          SRC_W     = 128,
  parameter int          SRC_H     = 128,
  parameter int          OUT_DIM   = 16,
  parameter int          DEC       = 8,
  parameter logic [7:0]  BIAS_BYTE = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_valid,
  input  logic               sof,
  input  logic [UINT_8-1:0]  pix,
  input  logic [ADR_LEN-1:0] rd_addr,
  output logic [UINT_8-1:0]  img_byte,
  output logic               img_ready,
  input  logic               img_done,
  output logic               frame_drop
);

  localparam int LOG_DEC = $clog2(DEC);
  localparam int ACC_W   = 8 + 2 * LOG_DEC;
  localparam int X_W     = $clog2(SRC_W);
  localparam int Y_W     = $clog2(SRC_H);
  localparam int COL_W   = $clog2(OUT_DIM);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_COMMIT  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic [ACC_W-1:0]   acc_q [OUT_DIM];
  logic [ACC_W-1:0]   acc_d [OUT_DIM];
  logic               wr_bank_q, wr_bank_d;
  logic               img_ready_q, img_ready_d;
  logic               frame_drop_q, frame_drop_d;

  logic               accept_s;
  logic               blk_end_s;
  logic               ready_eff_s;
  logic [X_W-1:0]     px_s;
  logic [Y_W-1:0]     py_s;
  logic [COL_W-1:0]   col_s;
  logic [ACC_W-1:0]   sum_s;
  logic               we_s;
  logic [IMG_AW-1:0]  waddr_s;
  logic [UINT_8-1:0]  wd_s;

  logic [IMG_AW-1:0]  raddr_s;
  logic [UINT_8-1:0]  rd0_s, rd1_s, bank_data_s;

  // Capture FSM, accumulation and commit/release bookkeeping
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    acc_d        = acc_q;
    wr_bank_d    = wr_bank_q;
    img_ready_d  = img_ready_q;
    frame_drop_d = 1'b0;
    we_s         = 1'b0;
    waddr_s      = '0;
    wd_s         = 8'h00;
    sum_s        = '0;

    accept_s    = pix_valid && (sof || (state_q == S_CAPTURE));
    px_s        = sof ? X_W'(0) : x_q;
    py_s        = sof ? Y_W'(0) : y_q;
    col_s       = COL_W'(px_s >> LOG_DEC);
    blk_end_s   = (&px_s[LOG_DEC-1:0]) && (&py_s[LOG_DEC-1:0]);
    // A release in the commit cycle is applied before the swap decision.
    ready_eff_s = img_ready_q && !img_done;

    if (state_q == S_COMMIT) begin
      if (ready_eff_s) begin
        frame_drop_d = 1'b1;
      end else begin
        wr_bank_d   = !wr_bank_q;
        img_ready_d = 1'b1;
      end
    end else begin
      img_ready_d = ready_eff_s;
    end

    if (accept_s) begin
      if (sof) begin
        for (int i = 0; i < OUT_DIM; i++) begin
          acc_d[i] = '0;
        end
      end else begin
        acc_d = acc_d;
      end

      sum_s = acc_d[col_s] + ACC_W'(pix);
      if (blk_end_s) begin
        we_s          = 1'b1;
        waddr_s       = IMG_AW'((32'(py_s) >> LOG_DEC) * OUT_DIM + 32'(col_s));
        wd_s          = UINT_8'(sum_s >> (2 * LOG_DEC));
        acc_d[col_s]  = '0;
      end else begin
        acc_d[col_s]  = sum_s;
      end

      if (px_s == X_W'(SRC_W - 1)) begin
        x_d = X_W'(0);
        if (py_s == Y_W'(SRC_H - 1)) begin
          y_d     = Y_W'(0);
          state_d = S_COMMIT;
        end else begin
          y_d     = py_s + Y_W'(1);
          state_d = S_CAPTURE;
        end
      end else begin
        x_d     = px_s + X_W'(1);
        y_d     = py_s;
        state_d = S_CAPTURE;
      end
    end else if (state_q == S_COMMIT) begin
      state_d = S_IDLE;
    end else begin
      state_d = state_q;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      for (int i = 0; i < OUT_DIM; i++) begin
        acc_q[i]   <= '0;
      end
      wr_bank_q    <= 1'b0;
      img_ready_q  <= 1'b0;
      frame_drop_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      acc_q        <= acc_d;
      wr_bank_q    <= wr_bank_d;
      img_ready_q  <= img_ready_d;
      frame_drop_q <= frame_drop_d;
    end
  end

  frame_bank u_bank0 (
    .clk   (clk),
    .reset (reset),
    .we    (we_s && !wr_bank_q),
    .waddr (waddr_s),
    .wd    (wd_s),
    .raddr (raddr_s),
    .rd    (rd0_s)
  );

  frame_bank u_bank1 (
    .clk   (clk),
    .reset (reset),
    .we    (we_s && wr_bank_q),
    .waddr (waddr_s),
    .wd    (wd_s),
    .raddr (raddr_s),
    .rd    (rd1_s)
  );

  // The read bank is always the one not being written.
  assign raddr_s     = IMG_AW'(rd_addr - ADR_LEN'(1));
  assign bank_data_s = wr_bank_q ? rd0_s : rd1_s;
  assign img_byte    = read_mux(rd_addr, BIAS_BYTE, bank_data_s);
  assign img_ready   = img_ready_q;
  assign frame_drop  = frame_drop_q;

endmodule

// File: tb/tb_img_decimator.sv
// Randomized self-checking bench for img_decimator using a frame-level reference model.
module tb_img_decimator;
  import img_decimator_pkg::*;

  localparam int SRC_W   = 64;
  localparam int SRC_H   = 64;
  localparam int OUT_DIM = 16;
  localparam int DEC     = 4;
  localparam int NPIX    = SRC_W * SRC_H;

  logic               clk       = 1'b0;
  logic               reset     = 1'b1;
  logic               pix_valid = 1'b0;
  logic               sof       = 1'b0;
  logic               img_done  = 1'b0;
  logic [7:0]         pix       = 8'h00;
  logic [ADR_LEN-1:0] rd_addr   = '0;
  logic [7:0]         img_byte;
  logic               img_ready;
  logic               frame_drop;

  int checks = 0;
  int errors = 0;
  int drops  = 0;

  // reference model state
  logic [7:0] cur      [NPIX];
  logic [7:0] done_img [256];
  logic [7:0] exp_rd   [256];
  bit         exp_ready      = 1'b0;
  bit         exp_drop       = 1'b0;
  bit         in_frame       = 1'b0;
  bit         commit_pending = 1'b0;
  int         cnt            = 0;

  img_decimator #(
    .SRC_W(SRC_W), .SRC_H(SRC_H), .OUT_DIM(OUT_DIM), .DEC(DEC), .BIAS_BYTE(8'hFF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_valid  (pix_valid),
    .sof        (sof),
    .pix        (pix),
    .rd_addr    (rd_addr),
    .img_byte   (img_byte),
    .img_ready  (img_ready),
    .img_done   (img_done),
    .frame_drop (frame_drop)
  );

  initial forever #5 clk = ~clk;

  function automatic void build_image();
    for (int r = 0; r < OUT_DIM; r++) begin
      for (int c = 0; c < OUT_DIM; c++) begin
        int s = 0;
        for (int dy = 0; dy < DEC; dy++)
          for (int dx = 0; dx < DEC; dx++)
            s += int'(cur[(r * DEC + dy) * SRC_W + c * DEC + dx]);
        done_img[r * OUT_DIM + c] = 8'(s / (DEC * DEC));
      end
    end
  endfunction

  function automatic logic [7:0] exp_byte(input logic [ADR_LEN-1:0] a);
    if (a == 0) return 8'hFF;
    if (int'(a) <= 256) return exp_rd[int'(a) - 1];
    return 8'h00;
  endfunction

  // frame-level model: a frame is complete after NPIX accepted pixels starting at sof,
  // and is handed over (or dropped) on the following cycle
  initial begin
    for (int i = 0; i < 256; i++) exp_rd[i] = 8'h00;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        for (int i = 0; i < 256; i++) exp_rd[i] = 8'h00;
        exp_ready = 1'b0; exp_drop = 1'b0; in_frame = 1'b0;
        commit_pending = 1'b0; cnt = 0;
      end else begin
        if (commit_pending) begin
          commit_pending = 1'b0;
          if (exp_ready && !img_done) begin
            exp_drop = 1'b1;
          end else begin
            exp_rd    = done_img;
            exp_ready = 1'b1;
            exp_drop  = 1'b0;
          end
        end else begin
          exp_drop = 1'b0;
          if (img_done) exp_ready = 1'b0;
        end
        if (pix_valid && (sof || in_frame)) begin
          if (sof) begin cnt = 0; in_frame = 1'b1; end
          cur[cnt] = pix;
          cnt++;
          if (cnt == NPIX) begin
            in_frame = 1'b0;
            build_image();
            commit_pending = 1'b1;
          end
        end
      end
    end
  end

  // per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (reset !== 1'b1) begin
      checks++;
      if (img_ready !== exp_ready) begin
        errors++;
        $display("FAIL img_ready @%0t: got %b expected %b", $time, img_ready, exp_ready);
      end
      checks++;
      if (frame_drop !== exp_drop) begin
        errors++;
        $display("FAIL frame_drop @%0t: got %b expected %b", $time, frame_drop, exp_drop);
      end
      checks++;
      if (img_byte !== exp_byte(rd_addr)) begin
        errors++;
        $display("FAIL img_byte @%0t addr %0d: got %h expected %h",
                 $time, rd_addr, img_byte, exp_byte(rd_addr));
      end
      if (frame_drop === 1'b1) drops++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic read_chk(input int addr, input int exp_v, input string name);
    @(posedge clk); #2;
    rd_addr = ADR_LEN'(addr);
    #1;
    chk($sformatf("%s[%0d]", name, addr), int'(img_byte), exp_v);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b0;
      sof       = 1'($urandom_range(0, 1));
      pix       = 8'($urandom);
      rd_addr   = ADR_LEN'($urandom_range(0, 300));
      @(posedge clk); #1;
    end
    sof = 1'b0;
  endtask

  task automatic drive_px(input logic [7:0] v, input logic s, input int gap);
    while ($urandom_range(0, 99) < gap) idle(1);
    pix_valid = 1'b1;
    sof       = s;
    pix       = v;
    rd_addr   = ADR_LEN'($urandom_range(0, 300));
    @(posedge clk); #1;
    pix_valid = 1'b0;
    sof       = 1'b0;
  endtask

  // kind 0: constant v; kind 1: pixel value equals its column
  task automatic send_frame(input int kind, input logic [7:0] v, input int lines, input int gap);
    for (int y = 0; y < lines; y++)
      for (int x = 0; x < SRC_W; x++)
        drive_px((kind == 0) ? v : 8'(x), (x == 0) && (y == 0), gap);
  endtask

  task automatic pulse_done();
    img_done = 1'b1;
    @(posedge clk); #1;
    img_done = 1'b0;
  endtask

  task automatic read_all(input int exp_v, input string name);
    for (int a = 1; a <= 256; a++) read_chk(a, exp_v, name);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    idle(2);
    chk("reset_ready", int'(img_ready), 0);
    chk("reset_drop", int'(frame_drop), 0);
    read_chk(0, 8'hFF, "reset_bias");
    read_chk(5, 8'h00, "reset_data");

    // uniform frame
    send_frame(0, 8'h80, SRC_H, 0);
    chk("ready_before_commit", int'(img_ready), 0);
    idle(1);
    chk("ready_after_commit", int'(img_ready), 1);
    idle(2);
    read_chk(0, 8'hFF, "flat_bias");
    read_all(8'h80, "flat");
    read_chk(257, 8'h00, "flat_beyond");
    chk("flat_drops", drops, 0);

    // ramp frame with gaps: average of x over each block truncates to DEC*c + 1
    pulse_done();
    send_frame(1, 8'h00, SRC_H, 12);
    idle(3);
    chk("ramp_ready", int'(img_ready), 1);
    for (int r = 0; r < OUT_DIM; r++)
      for (int c = 0; c < OUT_DIM; c++)
        read_chk(r * OUT_DIM + c + 1, 4 * c + 1, "ramp");

    // back-to-back frames without release
    pulse_done();
    send_frame(0, 8'h10, SRC_H, 0);
    idle(3);
    read_chk(17, 8'h10, "b2b_first");
    send_frame(0, 8'h20, SRC_H, 0);
    idle(3);
    chk("b2b_drops", drops, 1);
    read_chk(1, 8'h10, "b2b_kept");
    read_chk(256, 8'h10, "b2b_kept");
    pulse_done();
    send_frame(0, 8'h30, SRC_H, 0);
    idle(3);
    chk("third_ready", int'(img_ready), 1);
    read_all(8'h30, "third");

    // restart mid-frame with a new sof
    pulse_done();
    send_frame(0, 8'hFF, 40, 0);
    send_frame(0, 8'h04, SRC_H, 0);
    idle(3);
    read_all(8'h04, "restart");
    chk("restart_drops", drops, 1);
    chk("pre_reset_ready", int'(img_ready), 1);

    // asynchronous reset during capture
    send_frame(0, 8'h77, 60, 0);
    reset = 1'b1;
    #1;
    chk("async_reset_ready", int'(img_ready), 0);
    read_chk(9, 8'h00, "async_reset_data");
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 500; i++) drive_px(8'($urandom), 1'b0, 0);
    chk("no_sof_ready", int'(img_ready), 0);
    send_frame(0, 8'h55, SRC_H, 0);
    idle(3);
    read_all(8'h55, "post_reset");

    // release coincides with the commit cycle
    send_frame(0, 8'h66, SRC_H, 0);
    pulse_done();
    idle(2);
    chk("done_commit_ready", int'(img_ready), 1);
    chk("done_commit_drops", drops, 1);
    read_chk(1, 8'h66, "done_commit");
    read_chk(128, 8'h66, "done_commit");
    read_chk(256, 8'h66, "done_commit");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
